// File: rtl/reg_file_sb.sv
// Register file with ALU (A) and load (B) writeback ports, write-through read
// bypass, and a per-register pending scoreboard that raises stall on load-use.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              wrEnA,
    input  logic [ADDR_W-1:0] wrAddrA,
    input  logic [DATA_W-1:0] wrDataA,
    input  logic              wrEnB,
    input  logic [ADDR_W-1:0] wrAddrB,
    input  logic [DATA_W-1:0] wrDataB,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr,
    output logic              stall,
    output logic [ADDR_W:0]   busyCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic [ADDR_W:0]   busy_nxt;
    logic              we_a;
    logic              we_b;
    logic              iss;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign we_a = wrEnA      & ~is_zero(wrAddrA);
    assign we_b = wrEnB      & ~is_zero(wrAddrB);
    assign iss  = issueValid & ~is_zero(issueAddr);

    // Set is applied after clear so a re-issue on the writeback cycle stays pending.
    always_comb begin
        pending_nxt = pending;
        if (we_b) pending_nxt[wrAddrB]   = 1'b0;
        if (iss)  pending_nxt[issueAddr] = 1'b1;
        busy_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_nxt = busy_nxt + {{ADDR_W{1'b0}}, pending_nxt[i]};
        end
    end

    // Port B is assigned last so it wins a same-address write collision.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending   <= '0;
            busyCount <= '0;
        end else begin
            if (we_a) mem[wrAddrA] <= wrDataA;
            if (we_b) mem[wrAddrB] <= wrDataB;
            pending   <= pending_nxt;
            busyCount <= busy_nxt;
        end
    end

    always_comb begin
        readData1 = mem[rs];
        if (we_a && (wrAddrA == rs)) readData1 = wrDataA;
        if (we_b && (wrAddrB == rs)) readData1 = wrDataB;
        if (is_zero(rs))             readData1 = '0;
    end

    always_comb begin
        readData2 = mem[rt];
        if (we_a && (wrAddrA == rt)) readData2 = wrDataA;
        if (we_b && (wrAddrB == rt)) readData2 = wrDataB;
        if (is_zero(rt))             readData2 = '0;
    end

    // No handshake: writes are always accepted; the pipeline is expected to hold
    // the dependent instruction while stall is high. A same-cycle load
    // writeback to the register resolves its hazard through the bypass.
    function automatic logic hazard(input logic [ADDR_W-1:0] a);
        return pending[a] & ~(wrEnB && (wrAddrB == a)) & ~is_zero(a);
    endfunction

    assign stall = hazard(rs) | hazard(rt);

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic against a behavioural register/scoreboard model.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              CLK;
    logic              Reset;
    logic [ADDR_W-1:0] rs, rt;
    logic [DATA_W-1:0] readData1, readData2;
    logic              wrEnA, wrEnB, issueValid;
    logic [ADDR_W-1:0] wrAddrA, wrAddrB, issueAddr;
    logic [DATA_W-1:0] wrDataA, wrDataB;
    logic              stall;
    logic [ADDR_W:0]   busyCount;

    int checks = 0;
    int errors = 0;
    bit clk_run = 1'b1;

    logic [DATA_W-1:0] m_regs [DEPTH];
    bit                m_pend [DEPTH];

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .CLK(CLK), .Reset(Reset), .rs(rs), .rt(rt),
        .readData1(readData1), .readData2(readData2),
        .wrEnA(wrEnA), .wrAddrA(wrAddrA), .wrDataA(wrDataA),
        .wrEnB(wrEnB), .wrAddrB(wrAddrB), .wrDataB(wrDataB),
        .issueValid(issueValid), .issueAddr(issueAddr),
        .stall(stall), .busyCount(busyCount)
    );

    initial begin
        CLK = 1'b0;
        forever begin
            #5;
            if (clk_run) CLK = ~CLK;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (wrEnA && wrAddrA != 0) m_regs[wrAddrA] = wrDataA;
        if (wrEnB && wrAddrB != 0) m_regs[wrAddrB] = wrDataB;
        if (wrEnB && wrAddrB != 0) m_pend[wrAddrB] = 1'b0;
        if (issueValid && issueAddr != 0) m_pend[issueAddr] = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wrEnB && wrAddrB == a) return wrDataB;
        if (wrEnA && wrAddrA == a) return wrDataA;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        logic s1, s2;
        s1 = m_pend[rs] && !(wrEnB && wrAddrB == rs) && rs != 0;
        s2 = m_pend[rt] && !(wrEnB && wrAddrB == rt) && rt != 0;
        return s1 || s2;
    endfunction

    function automatic int exp_busy();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        wrEnA = 0; wrAddrA = '0; wrDataA = '0;
        wrEnB = 0; wrAddrB = '0; wrDataB = '0;
        issueValid = 0; issueAddr = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (Reset) model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b0;
        idle_inputs();
        rs = 5'd1; rt = 5'd2;
        #3;
        checks++; if (busyCount !== 0) begin errors++; $display("FAIL reset_busy got %0d want 0", busyCount); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        Reset = 1'b1;
        model_reset();
        wrEnA = 1; wrAddrA = 5'd1; wrDataA = 32'h0000_00AA;
        issueValid = 1; issueAddr = 5'd2;
        tick();
        idle_inputs();
        @(negedge CLK);
        clk_run = 1'b0;
        #1;
        checks++; if (readData1 !== 32'hAA) begin errors++; $display("FAIL pre_reset_rd1 got %h want 000000aa", readData1); end
        checks++; if (busyCount !== 1) begin errors++; $display("FAIL pre_reset_busy got %0d want 1", busyCount); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (readData1 !== 0) begin errors++; $display("FAIL stopped_reset_rd1 got %h want 0", readData1); end
        checks++; if (readData2 !== 0) begin errors++; $display("FAIL stopped_reset_rd2 got %h want 0", readData2); end
        checks++; if (busyCount !== 0) begin errors++; $display("FAIL stopped_reset_busy got %0d want 0", busyCount); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stopped_reset_stall got %b want 0", stall); end
        #1;
        Reset = 1'b1;
        model_reset();
        clk_run = 1'b1;
        tick();
    endtask

    task automatic test_write_bypass();
        idle_inputs();
        wrEnA = 1; wrAddrA = 5'd2; wrDataA = 32'd1; rs = 5'd2;
        #1;
        checks++; if (readData1 !== 32'd1) begin errors++; $display("FAIL bypass_a_rd1 got %h want 1", readData1); end
        tick();
        idle_inputs();
        #1;
        checks++; if (readData1 !== 32'd1) begin errors++; $display("FAIL stored_a_rd1 got %h want 1", readData1); end
        wrEnA = 1; wrAddrA = 5'd0; wrDataA = 32'd7; rs = 5'd0;
        #1;
        checks++; if (readData1 !== 0) begin errors++; $display("FAIL zero_bypass_rd1 got %h want 0", readData1); end
        tick();
        idle_inputs();
        #1;
        checks++; if (readData1 !== 0) begin errors++; $display("FAIL zero_stored_rd1 got %h want 0", readData1); end
    endtask

    task automatic test_dual_conflict();
        idle_inputs();
        wrEnA = 1; wrAddrA = 5'd5; wrDataA = 32'd3;
        wrEnB = 1; wrAddrB = 5'd5; wrDataB = 32'd4;
        rs = 5'd5; rt = 5'd5;
        #1;
        checks++; if (readData1 !== 32'd4) begin errors++; $display("FAIL conflict_bypass_rd1 got %h want 4", readData1); end
        tick();
        idle_inputs();
        #1;
        checks++; if (readData2 !== 32'd4) begin errors++; $display("FAIL conflict_stored_rd2 got %h want 4", readData2); end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        rs = 5'd0; rt = 5'd4;
        issueValid = 1; issueAddr = 5'd4;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_issue_cycle_stall got %b want 0", stall); end
        tick();
        idle_inputs();
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_pending_stall got %b want 1", stall); end
        checks++; if (busyCount !== 1) begin errors++; $display("FAIL sb_pending_busy got %0d want 1", busyCount); end
        tick();
        wrEnB = 1; wrAddrB = 5'd4; wrDataB = 32'd9;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_wb_stall got %b want 0", stall); end
        checks++; if (readData2 !== 32'd9) begin errors++; $display("FAIL sb_wb_rd2 got %h want 9", readData2); end
        checks++; if (busyCount !== 1) begin errors++; $display("FAIL sb_wb_busy_before got %0d want 1", busyCount); end
        tick();
        idle_inputs();
        #1;
        checks++; if (busyCount !== 0) begin errors++; $display("FAIL sb_cleared_busy got %0d want 0", busyCount); end
    endtask

    task automatic test_collision();
        idle_inputs();
        rs = 5'd0; rt = 5'd0;
        issueValid = 1; issueAddr = 5'd3; tick();
        issueAddr = 5'd6; tick();
        idle_inputs(); #1;
        checks++; if (busyCount !== 2) begin errors++; $display("FAIL col_two_busy got %0d want 2", busyCount); end
        issueValid = 1; issueAddr = 5'd3; tick();
        idle_inputs(); #1;
        checks++; if (busyCount !== 2) begin errors++; $display("FAIL col_reissue_busy got %0d want 2", busyCount); end
        issueValid = 1; issueAddr = 5'd7;
        wrEnB = 1; wrAddrB = 5'd3; wrDataB = 32'h33; tick();
        idle_inputs(); #1;
        checks++; if (busyCount !== 2) begin errors++; $display("FAIL col_set_clear_busy got %0d want 2", busyCount); end
        issueValid = 1; issueAddr = 5'd6;
        wrEnB = 1; wrAddrB = 5'd6; wrDataB = 32'h66; tick();
        idle_inputs(); rs = 5'd6; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL col_same_addr_stall got %b want 1", stall); end
        checks++; if (busyCount !== 2) begin errors++; $display("FAIL col_same_addr_busy got %0d want 2", busyCount); end
        checks++; if (readData1 !== 32'h66) begin errors++; $display("FAIL col_same_addr_rd1 got %h want 66", readData1); end
    endtask

    task automatic test_reset_midop();
        idle_inputs();
        wrEnA = 1; wrAddrA = 5'd10; wrDataA = 32'hDEAD_BEEF;
        issueValid = 1; issueAddr = 5'd8; tick();
        wrAddrA = 5'd11; wrDataA = 32'h1234_5678; issueValid = 0; tick();
        idle_inputs(); rs = 5'd10; rt = 5'd6; #1;
        checks++; if (busyCount !== 3) begin errors++; $display("FAIL mid_pre_busy got %0d want 3", busyCount); end
        checks++; if (readData1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_pre_rd1 got %h want deadbeef", readData1); end
        issueValid = 1; issueAddr = 5'd9;
        #1;
        Reset = 1'b0;
        #1;
        checks++; if (readData1 !== 0) begin errors++; $display("FAIL mid_reset_rd1 got %h want 0", readData1); end
        checks++; if (readData2 !== 0) begin errors++; $display("FAIL mid_reset_rd2 got %h want 0", readData2); end
        checks++; if (busyCount !== 0) begin errors++; $display("FAIL mid_reset_busy got %0d want 0", busyCount); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall got %b want 0", stall); end
        model_reset();
        tick();
        idle_inputs();
        Reset = 1'b1;
        rt = 5'd9; rs = 5'd11;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_dropped_issue_stall got %b want 0", stall); end
        checks++; if (readData1 !== 0) begin errors++; $display("FAIL mid_after_rd1 got %h want 0", readData1); end
        tick();
        #1;
        checks++; if (busyCount !== 0) begin errors++; $display("FAIL mid_after_busy got %0d want 0", busyCount); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e1, e2;
        logic              es;
        int                eb;
        for (int n = 0; n < 400; n++) begin
            rs         = ADDR_W'($urandom_range(0, 9));
            rt         = ADDR_W'($urandom_range(0, 9));
            wrEnA      = ($urandom_range(0, 2) == 0);
            wrAddrA    = ADDR_W'($urandom_range(0, 9));
            wrDataA    = $urandom;
            wrEnB      = ($urandom_range(0, 2) == 0);
            wrAddrB    = ADDR_W'($urandom_range(0, 9));
            wrDataB    = $urandom;
            issueValid = ($urandom_range(0, 2) == 0);
            issueAddr  = ADDR_W'($urandom_range(0, 9));
            #1;
            e1 = exp_read(rs);
            e2 = exp_read(rt);
            es = exp_stall();
            checks++; if (readData1 !== e1) begin errors++; $display("FAIL rand_rd1 iter %0d got %h want %h", n, readData1, e1); end
            checks++; if (readData2 !== e2) begin errors++; $display("FAIL rand_rd2 iter %0d got %h want %h", n, readData2, e2); end
            checks++; if (stall !== es) begin errors++; $display("FAIL rand_stall iter %0d got %b want %b", n, stall, es); end
            tick();
            eb = exp_busy();
            checks++; if (int'(busyCount) !== eb) begin errors++; $display("FAIL rand_busy iter %0d got %0d want %0d", n, busyCount, eb); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_dual_conflict();
        test_scoreboard();
        test_collision();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
